// File: rtl/ipv4_header_extract_if.sv
// AXI-Stream bundle used for both the byte-lane packet input and the
// single-beat header output of ipv4_header_extract.
interface axis_int #(
  parameter int DATA_BYTES = 8
);
  logic [8*DATA_BYTES-1:0] tdata;
  logic [DATA_BYTES-1:0]   tkeep;
  logic                    tvalid;
  logic                    tready;
  logic                    tlast;

  modport master (output tdata, tkeep, tvalid, tlast, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, output tready);
endinterface

// File: rtl/ipv4_header_extract.sv
// Captures the first 20 bytes of each IPv4 packet as one 160-bit word, drops
// and counts runts and non-option-less headers, and discards the payload.
module ipv4_header_extract #(
  parameter int DATA_BYTES = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 aresetn,
  axis_int.slave               in_axis,
  axis_int.master              ipv4_header,
  output logic [CNT_WIDTH-1:0] runt_count,
  output logic [CNT_WIDTH-1:0] bad_hdr_count
);

  localparam int HDR_BYTES = 20;

  typedef enum logic {
    S_HDR,
    S_SKIP
  } state_e;

  state_e                        state_q, state_d;
  logic [4:0]                    byte_cnt_q, byte_cnt_d;
  logic [HDR_BYTES-1:0][7:0]     hdr_q, hdr_d;
  logic [8*HDR_BYTES-1:0]        out_data_q, out_data_d;
  logic                          out_valid_q, out_valid_d;
  logic [CNT_WIDTH-1:0]          runt_q, runt_d;
  logic [CNT_WIDTH-1:0]          bad_q, bad_d;

  logic                          accept;
  logic [3:0]                    keep_cnt;
  logic [5:0]                    total;
  logic                          hdr_ok;
  logic                          unused_tready;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == '1) ? v : v + CNT_WIDTH'(1);
  endfunction

  // Ready follows reset directly: the block never stalls once out of reset.
  assign in_axis.tready = aresetn;
  assign accept         = in_axis.tvalid & in_axis.tready;

  always_comb begin
    keep_cnt = '0;
    for (int i = 0; i < DATA_BYTES; i++) begin
      keep_cnt = keep_cnt + 4'(in_axis.tkeep[i]);
    end
  end

  assign total = {1'b0, byte_cnt_q} + {2'b0, keep_cnt};

  // Header byte j lives at hdr[19-j] so the packed word puts wire byte 0 on top.
  always_comb begin
    hdr_d = hdr_q;
    if (accept && state_q == S_HDR) begin
      for (int j = 0; j < HDR_BYTES; j++) begin
        for (int i = 0; i < DATA_BYTES; i++) begin
          if (in_axis.tkeep[i] && ({1'b0, byte_cnt_q} + 6'(i) == 6'(j))) begin
            hdr_d[HDR_BYTES-1-j] = in_axis.tdata[8*i +: 8];
          end
        end
      end
    end
  end

  // Evaluated on the merged bytes so the completing beat's lanes count.
  assign hdr_ok = (hdr_d[HDR_BYTES-1] == 8'h45);

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    runt_d      = runt_q;
    bad_d       = bad_q;
    if (accept) begin
      case (state_q)
        S_HDR: begin
          if (total >= 6'(HDR_BYTES)) begin
            if (hdr_ok) begin
              out_valid_d = 1'b1;
              out_data_d  = hdr_d;
            end else begin
              bad_d = sat_inc(bad_q);
            end
            if (in_axis.tlast) begin
              byte_cnt_d = '0;
            end else begin
              byte_cnt_d = 5'(HDR_BYTES);
              state_d    = S_SKIP;
            end
          end else if (in_axis.tlast) begin
            runt_d     = sat_inc(runt_q);
            byte_cnt_d = '0;
          end else begin
            byte_cnt_d = total[4:0];
          end
        end
        S_SKIP: begin
          if (in_axis.tlast) begin
            byte_cnt_d = '0;
            state_d    = S_HDR;
          end
        end
        default: begin
          byte_cnt_d = '0;
          state_d    = S_HDR;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= S_HDR;
      byte_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      runt_q      <= '0;
      bad_q       <= '0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      runt_q      <= runt_d;
      bad_q       <= bad_d;
    end
  end

  // NOTE: the byte staging buffer is not reset; all 20 bytes are rewritten
  // before any of them can reach the output.
  always_ff @(posedge clk) begin
    hdr_q <= hdr_d;
  end

  assign ipv4_header.tdata  = out_data_q;
  assign ipv4_header.tvalid = out_valid_q;
  assign ipv4_header.tkeep  = '1;
  assign ipv4_header.tlast  = out_valid_q;
  assign unused_tready      = ipv4_header.tready;

  assign runt_count    = runt_q;
  assign bad_hdr_count = bad_q;

endmodule

// File: tb/tb_ipv4_header_extract.sv
// Directed bench for ipv4_header_extract: an 8-byte-lane instance for packet
// framing cases and a 1-byte-lane instance for input bubbles.
module tb_ipv4_header_extract;

  localparam logic [159:0] H_GOOD = 160'h45000073_00004000_4011b861_c0a80001_c0a800c7;
  localparam logic [159:0] H_B    = 160'h4500003c_1c464000_40060000_0a000001_0a000002;
  localparam logic [159:0] H_V6   = 160'h65000073_00004000_4011b861_c0a80001_c0a800c7;
  localparam logic [159:0] H_IHL6 = 160'h46000073_00004000_4011b861_c0a80001_c0a800c7;

  logic clk = 1'b0;
  logic aresetn = 1'b0;
  always #5 clk = ~clk;

  axis_int #(.DATA_BYTES(8))  in8 ();
  axis_int #(.DATA_BYTES(20)) hdr8 ();
  axis_int #(.DATA_BYTES(1))  in1 ();
  axis_int #(.DATA_BYTES(20)) hdr1 ();

  logic [15:0] runt8, bad8, runt1, bad1;

  assign hdr8.tready = 1'b1;
  assign hdr1.tready = 1'b1;

  ipv4_header_extract #(.DATA_BYTES(8), .CNT_WIDTH(16)) u_dut8 (
    .clk           (clk),
    .aresetn       (aresetn),
    .in_axis       (in8),
    .ipv4_header   (hdr8),
    .runt_count    (runt8),
    .bad_hdr_count (bad8)
  );

  ipv4_header_extract #(.DATA_BYTES(1), .CNT_WIDTH(16)) u_dut1 (
    .clk           (clk),
    .aresetn       (aresetn),
    .in_axis       (in1),
    .ipv4_header   (hdr1),
    .runt_count    (runt1),
    .bad_hdr_count (bad1)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int pulses8  = 0;
  int pulses1  = 0;

  always @(negedge clk) begin
    if (hdr8.tvalid === 1'b1) pulses8++;
    if (hdr1.tvalid === 1'b1) pulses1++;
  end

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One's-complement fold of the ten header words; a correct header gives ffff.
  function automatic logic [15:0] csum_fold(input logic [159:0] h);
    logic [31:0] s;
    s = '0;
    for (int w = 0; w < 10; w++) s = s + {16'h0, h[159-16*w -: 16]};
    s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
    s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
    return s[15:0];
  endfunction

  task automatic idle(input int n);
    in8.tvalid = 1'b0;
    in8.tlast  = 1'b0;
    in1.tvalid = 1'b0;
    in1.tlast  = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic beat8(input logic [63:0] d, input logic [7:0] k, input logic l,
                       input logic exp_pulse, input string tag);
    in8.tdata  = d;
    in8.tkeep  = k;
    in8.tlast  = l;
    in8.tvalid = 1'b1;
    @(negedge clk);
    check(tag, hdr8.tvalid, exp_pulse);
  endtask

  // Header bytes first, then payload bytes equal to their wire offset.
  // A pulse is expected only after beat 2 (bytes 16..23) of a good packet.
  task automatic send_pkt8(input logic [159:0] h, input int len, input logic good, input string tag);
    for (int b = 0; b * 8 < len; b++) begin
      logic [63:0] d;
      logic [7:0]  k;
      d = '0;
      k = '0;
      for (int i = 0; i < 8; i++) begin
        int p;
        p = b * 8 + i;
        if (p < len) begin
          k[i] = 1'b1;
          d[8*i +: 8] = (p < 20) ? h[159-8*p -: 8] : 8'(p);
        end
      end
      beat8(d, k, (b + 1) * 8 >= len, good && (b == 2), tag);
    end
  endtask

  task automatic send_pkt1_bubbles(input logic [159:0] h);
    for (int p = 0; p < 20; p++) begin
      int nb;
      nb = (p == 10) ? 2 : int'($urandom_range(0, 1));
      repeat (nb) begin
        in1.tvalid = 1'b0;
        in1.tlast  = 1'b1;
        in1.tdata  = 8'($urandom);
        @(negedge clk);
        check("bubble_quiet", hdr1.tvalid, 1'b0);
      end
      in1.tdata  = h[159-8*p -: 8];
      in1.tkeep  = 1'b1;
      in1.tlast  = (p == 19);
      in1.tvalid = 1'b1;
      @(negedge clk);
      check("bubble_pulse", hdr1.tvalid, p == 19);
    end
    in1.tvalid = 1'b0;
    in1.tlast  = 1'b0;
  endtask

  initial begin
    in8.tdata = '0; in8.tkeep = '0; in8.tlast = 1'b0; in8.tvalid = 1'b0;
    in1.tdata = '0; in1.tkeep = '0; in1.tlast = 1'b0; in1.tvalid = 1'b0;
    aresetn = 1'b0;
    repeat (2) @(negedge clk);

    check("rst_tready", in8.tready, 1'b0);
    check("rst_tvalid", hdr8.tvalid, 1'b0);
    check("rst_tdata", hdr8.tdata, '0);
    check("rst_runt", runt8, '0);
    check("rst_bad", bad8, '0);
    aresetn = 1'b1;
    @(negedge clk);
    check("tready_up", in8.tready, 1'b1);

    // Exact 20-byte packet: FF, FF, 0F(last)
    send_pkt8(H_GOOD, 20, 1'b1, "exact20_beat");
    idle(2);
    #1;
    check("exact20_pulses", pulses8, 1);
    check("exact20_tdata", hdr8.tdata, H_GOOD);
    check("exact20_csum", csum_fold(hdr8.tdata), 16'hffff);

    // 60-byte then 40-byte packet, back to back
    send_pkt8(H_GOOD, 60, 1'b1, "p60_beat");
    send_pkt8(H_B, 40, 1'b1, "p40_beat");
    idle(2);
    #1;
    check("b2b_pulses", pulses8, 3);
    check("b2b_tdata", hdr8.tdata, H_B);

    // Bad version, then bad IHL
    send_pkt8(H_V6, 20, 1'b0, "ver6_beat");
    send_pkt8(H_IHL6, 24, 1'b0, "ihl6_beat");
    idle(2);
    #1;
    check("bad_count", bad8, 16'd2);
    check("bad_runt_zero", runt8, 16'd0);
    check("bad_pulses", pulses8, 3);
    check("bad_tdata_hold", hdr8.tdata, H_B);

    // 12-byte runt, then a good packet
    send_pkt8(H_GOOD, 12, 1'b0, "runt_beat");
    idle(1);
    #1;
    check("runt_count", runt8, 16'd1);
    send_pkt8(H_GOOD, 28, 1'b1, "after_runt_beat");
    idle(2);
    #1;
    check("after_runt_pulses", pulses8, 4);
    check("after_runt_tdata", hdr8.tdata, H_GOOD);
    check("after_runt_bad", bad8, 16'd2);

    // Byte-wide lanes with bubbles
    send_pkt1_bubbles(H_GOOD);
    idle(2);
    #1;
    check("bubble_pulses", pulses1, 1);
    check("bubble_tdata", hdr1.tdata, H_GOOD);
    check("bubble_runt", runt1, 16'd0);
    check("bubble_bad", bad1, 16'd0);

    // Reset in the middle of a packet
    beat8(H_B[159:96], 8'hff, 1'b0, 1'b0, "rst_mid_beat");
    in8.tvalid = 1'b0;
    @(posedge clk);
    #2 aresetn = 1'b0;
    #1;
    check("rst_mid_tvalid", hdr8.tvalid, 1'b0);
    check("rst_mid_tready", in8.tready, 1'b0);
    check("rst_mid_runt", runt8, '0);
    check("rst_mid_bad", bad8, '0);
    check("rst_mid_tdata", hdr8.tdata, '0);
    @(negedge clk);
    aresetn = 1'b1;
    send_pkt8(H_B, 20, 1'b1, "post_rst_beat");
    idle(2);
    #1;
    check("post_rst_pulses", pulses8, 5);
    check("post_rst_tdata", hdr8.tdata, H_B);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ipv4_header_extract.md
# ipv4_header_extract

Parses an incoming AXI-Stream packet carrying an IPv4 datagram and captures its first 20 bytes as a single 160-bit header word. It sits directly upstream of the checksum verify stage and drives that stage's 20-byte, no-backpressure header stream. Packets that cannot carry a valid option-less IPv4 header are dropped and counted. The rest of each packet is consumed and discarded.

## Interface
- DATA_BYTES, 8, input beat width in bytes; legal values 1, 2, 4, 8.
- CNT_WIDTH, 16, width of the drop counters.

- clk  in  1  clock; all ports are synchronous to it.
- aresetn  in  1  reset, asynchronous and active-low.
- in_axis  AXIS_int slave  DATA_BYTES  packet stream carrying tdata, tkeep, tvalid, tready and tlast.
- ipv4_header  AXIS_int master  20 bytes  header word; ALLOW_BACKPRESSURE=0, so tready is ignored.
- runt_count  out  CNT_WIDTH  number of packets that ended before 20 bytes; saturating.
- bad_hdr_count  out  CNT_WIDTH  number of packets with version≠4 or IHL≠5; saturating.

## Operation
- Byte order on input:
  - Lane 0 (tdata[7:0]) is the earliest byte on the wire.
  - tkeep is contiguous from bit 0.
  - Only a tlast beat may be partial.
  - A beat always has at least one keep bit set.
- Byte order on output:
  - Wire byte 0 (version/IHL) goes to tdata[159:152].
  - Wire byte 19 goes to tdata[7:0].
  - This matches the packed ipv4_header_t layout.
- in_axis.tready is 0 while reset is asserted and 1 at all other times. The block never stalls.
- A 5-bit byte counter byte_cnt counts 0..20.
- A beat is accepted when tvalid && tready.
- Lane i of an accepted beat is stored at header byte byte_cnt+i when two conditions hold:
  - its tkeep bit is set;
  - byte_cnt+i < 20.
- byte_cnt then advances by popcount(tkeep), saturating at 20.
- FSM states:
  - HDR (reset state): collecting header bytes.
    - The accepted beat brings the total to ≥20 bytes and has no tlast: evaluate the header, then go to SKIP.
    - It reaches ≥20 bytes and has tlast: evaluate the header, stay in HDR, clear byte_cnt.
    - It has tlast with a total below 20: increment runt_count, emit nothing, clear byte_cnt, stay in HDR.
  - SKIP: discard beats until tlast is accepted, then clear byte_cnt and go to HDR.
- Header evaluation uses the completed 20 bytes, including lanes stored in the completing beat:
  - Version==4 and IHL==5: emit the header.
  - Otherwise: increment bad_hdr_count and emit nothing.
- The checksum is not examined here; that is done downstream.
- Counters saturate at all-ones and never wrap.

## Timing
- Reset values:
  - ipv4_header.tvalid=0.
  - ipv4_header.tdata=0.
  - runt_count=0 and bad_hdr_count=0.
  - in_axis.tready=0.
  - FSM=HDR and byte_cnt=0.
- Latency:
  - ipv4_header.tvalid rises on the clock edge after the accepted beat that completes byte 19.
  - That is 1 cycle of latency.
  - tvalid is a single-cycle pulse.
- ipv4_header.tdata is registered together with tvalid. It holds its value between pulses.
- At most one pulse is produced per packet.
- Back-to-back packets with no idle cycle are supported. The beat after a tlast is byte 0 of the next packet, in both HDR and SKIP.
- Input bubbles (tvalid=0) do not change state, byte_cnt or the outputs.
- Counter updates take effect on the clock edge after the triggering beat.
- Reset mid-packet:
  - All state, outputs and counters clear immediately; this is asynchronous.
  - The first beat accepted after release is treated as byte 0 of a packet.
  - Upstream must be reset together with this block.

## Test plan
- **Exact 20-byte packet**, DATA_BYTES=8. Stimulus: beats with tkeep FF, FF, 0F (tlast) carrying a header with version 4, IHL 5 and a correct checksum. Required response:
  - one tvalid pulse exactly one cycle after the third beat;
  - tdata equals the packed header;
  - the downstream checksum stage reports valid=1.
- **60-byte packet followed back-to-back by a 40-byte packet.** Required response:
  - exactly two pulses;
  - the second pulse occurs one cycle after the beat containing byte 19 of packet 2;
  - no pulse during the skipped payload beats.
- **12-byte runt packet** (FF, 0F with tlast). Required response: no pulse, runt_count=1. The next valid packet is still extracted correctly.
- **Bad header fields.** Stimulus: a packet with version=6, then a packet with IHL=6. Required response: no pulses, bad_hdr_count=2, runt_count=0.
- **Input bubbles**, DATA_BYTES=1. Stimulus: 20-byte packet with tvalid deasserted on random cycles. Required response: one pulse, one cycle after byte 19, with correct tdata.
- **Reset mid-packet.** Stimulus: assert aresetn=0 mid-cycle after beat 1 of a packet. Required response:
  - tvalid, tready and both counters read 0 immediately;
  - after release, a fresh 20-byte packet produces one correct pulse.
